// File: rtl/seg7_multi_ctrl.sv
// Avalon-MM seven-segment controller for up to eight digits: per-digit data,
// optional hex decode, blank/blink/DP masks, static and scanned outputs.
module seg7_multi_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [8*NUM_DIGITS-1:0] seg_static,
    output logic [6:0]              seg_mux,
    output logic                    dp_mux,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic               OFF_LVL    = (SEG_ACTIVE_LOW != 0);

    logic [2:0]              ctrl_q, ctrl_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d, blink_q, blink_d, dp_q, dp_d;
    logic [6:0]              digit_q [NUM_DIGITS];
    logic [6:0]              digit_d [NUM_DIGITS];
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [8*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic                    dp_mux_q, dp_mux_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [NUM_DIGITS-1:0]   vis_w;
    logic [7:0]              byte_w [NUM_DIGITS];
    logic                    en, dec, blink_en, wr;
    logic                    unused_wdata;

    assign en           = ctrl_q[0];
    assign dec          = ctrl_q[1];
    assign blink_en     = ctrl_q[2];
    assign unused_wdata = ^writedata;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Bus: a write is accepted on any clk edge with chipselect high and write_n low,
    // with no wait state; readdata is a pure function of address and needs no select.
    always_comb begin
        wr      = chipselect && !write_n;
        ctrl_d  = ctrl_q;
        blank_d = blank_q;
        blink_d = blink_q;
        dp_d    = dp_q;
        digit_d = digit_q;
        if (wr) begin
            case (address)
                4'd0:    ctrl_d  = writedata[2:0];
                4'd1:    blank_d = writedata[NUM_DIGITS-1:0];
                4'd2:    blink_d = writedata[NUM_DIGITS-1:0];
                4'd3:    dp_d    = writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr && address == 4'(4 + i)) digit_d[i] = writedata[6:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0:    readdata[2:0]            = ctrl_q;
            4'd1:    readdata[NUM_DIGITS-1:0] = blank_q;
            4'd2:    readdata[NUM_DIGITS-1:0] = blink_q;
            4'd3:    readdata[NUM_DIGITS-1:0] = dp_q;
            default: ;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(4 + i)) readdata = {25'd0, digit_q[i]};
        end
    end

    // Scan slot and blink counters; both sit at zero while their enable is off.
    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!en) begin
            scan_cnt_d = '0;
            scan_idx_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
        if (!blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Per-digit byte {DP, g..a}, polarity applied last so masks stay active-high.
    always_comb begin
        vis_w        = '0;
        seg_static_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            vis_w[i]  = en && !blank_q[i] && !(blink_en && blink_q[i] && blink_phase_q);
            byte_w[i] = {vis_w[i] && dp_q[i],
                         vis_w[i] ? (dec ? hex7(digit_q[i][3:0]) : digit_q[i]) : 7'h00}
                        ^ {8{OFF_LVL}};
            seg_static_d[8*i +: 8] = byte_w[i];
        end
        seg_mux_d = byte_w[scan_idx_q][6:0];
        dp_mux_d  = byte_w[scan_idx_q][7];
        dig_sel_d = '0;
        if (en) dig_sel_d[scan_idx_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            blank_q       <= '0;
            blink_q       <= '0;
            dp_q          <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_static_q  <= {(8*NUM_DIGITS){OFF_LVL}};
            seg_mux_q     <= {7{OFF_LVL}};
            dp_mux_q      <= OFF_LVL;
            dig_sel_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            blank_q       <= blank_d;
            blink_q       <= blink_d;
            dp_q          <= dp_d;
            digit_q       <= digit_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_static_q  <= seg_static_d;
            seg_mux_q     <= seg_mux_d;
            dp_mux_q      <= dp_mux_d;
            dig_sel_q     <= dig_sel_d;
        end
    end

    assign seg_static = seg_static_q;
    assign seg_mux    = seg_mux_q;
    assign dp_mux     = dp_mux_q;
    assign dig_sel    = dig_sel_q;

endmodule

// File: tb/tb_seg7_multi_ctrl.sv
// Bench for seg7_multi_ctrl: 4 digits, short scan/blink dividers, active-low segments.
// A time-based register model is checked every cycle, pinned by directed literals.
module tb_seg7_multi_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 8;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] seg_static;
    logic [6:0]  seg_mux;
    logic        dp_mux;
    logic [3:0]  dig_sel;

    seg7_multi_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .seg_static(seg_static), .seg_mux(seg_mux), .dp_mux(dp_mux), .dig_sel(dig_sel)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [2:0]    ctrl_m;
    logic [ND-1:0] blank_m, blink_m, dp_m;
    logic [6:0]    dig_m [ND];
    int            scan_t, blink_t;
    logic [31:0]   exp_static;
    logic [7:0]    exp_mux_byte;
    logic [ND-1:0] exp_dig_sel;

    function automatic logic [7:0] model_byte(input int i, input int phase);
        logic       vis;
        logic [6:0] seg;
        vis = ctrl_m[0] && !blank_m[i] && !(ctrl_m[2] && blink_m[i] && phase == 1);
        seg = ctrl_m[1] ? hex_tab[dig_m[i][3:0]] : dig_m[i];
        return ~(vis ? {dp_m[i], seg} : 8'h00);
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return {29'd0, ctrl_m};
        if (ai == 1) return {28'd0, blank_m};
        if (ai == 2) return {28'd0, blink_m};
        if (ai == 3) return {28'd0, dp_m};
        if (ai >= 4 && ai < 4 + ND) return {25'd0, dig_m[ai-4]};
        return 32'd0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_m       <= '0;
            blank_m      <= '0;
            blink_m      <= '0;
            dp_m         <= '0;
            for (int i = 0; i < ND; i++) dig_m[i] <= '0;
            scan_t       <= 0;
            blink_t      <= 0;
            exp_static   <= '1;
            exp_mux_byte <= 8'hFF;
            exp_dig_sel  <= '0;
        end else begin
            for (int i = 0; i < ND; i++)
                exp_static[8*i +: 8] <= model_byte(i, (blink_t / BD) % 2);
            exp_mux_byte <= model_byte((scan_t / SD) % ND, (blink_t / BD) % 2);
            exp_dig_sel  <= ctrl_m[0] ? ND'(1 << ((scan_t / SD) % ND)) : '0;
            scan_t       <= ctrl_m[0] ? scan_t + 1 : 0;
            blink_t      <= ctrl_m[2] ? blink_t + 1 : 0;
            if (chipselect && !write_n) begin
                if (address == 4'd0) ctrl_m  <= writedata[2:0];
                if (address == 4'd1) blank_m <= writedata[ND-1:0];
                if (address == 4'd2) blink_m <= writedata[ND-1:0];
                if (address == 4'd3) dp_m    <= writedata[ND-1:0];
                if (int'(address) >= 4 && int'(address) < 4 + ND)
                    dig_m[int'(address) - 4] <= writedata[6:0];
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always begin
        @(posedge clk);
        #1;
        if (chk_on) begin
            check("cmp_seg_static", seg_static, exp_static);
            check("cmp_seg_mux", {25'd0, seg_mux}, {25'd0, exp_mux_byte[6:0]});
            check("cmp_dp_mux", {31'd0, dp_mux}, {31'd0, exp_mux_byte[7]});
            check("cmp_dig_sel", {28'd0, dig_sel}, {28'd0, exp_dig_sel});
            check("cmp_readdata", readdata, model_read(address));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 4'd0;
        writedata  = 32'd0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic next_out();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [6:0] scan_seg [4] = '{7'h40, 7'h24, 7'h08, 7'h0E};

    initial begin
        bus_idle();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        chk_on  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // reset state
        check("rst_seg_static", seg_static, 32'hFFFF_FFFF);
        check("rst_seg_mux", {25'd0, seg_mux}, 32'h7F);
        check("rst_dp_mux", {31'd0, dp_mux}, 32'd1);
        check("rst_dig_sel", {28'd0, dig_sel}, 32'd0);
        for (int a = 0; a < 8; a++) bus_read(4'(a), 32'd0, "rst_read");

        // hex decode
        bus_write(4'd4, 32'h0);
        bus_write(4'd5, 32'h8);
        bus_write(4'd6, 32'hA);
        bus_write(4'd7, 32'hF);
        bus_write(4'd0, 32'h3);
        next_out();
        check("dec_bytes", seg_static, 32'h8E88_80C0);
        bus_write(4'd0, 32'h1);
        bus_write(4'd5, 32'h12);
        check("raw_byte1_before", {24'd0, seg_static[15:8]}, 32'hF7);
        next_out();
        check("raw_byte1_after", {24'd0, seg_static[15:8]}, 32'hED);

        // scan
        bus_write(4'd0, 32'h0);
        bus_write(4'd0, 32'h3);
        for (int j = 0; j < 20; j++) begin
            next_out();
            check("scan_dig_sel", {28'd0, dig_sel}, 32'(1 << ((j / 4) % 4)));
            check("scan_seg_mux", {25'd0, seg_mux}, {25'd0, scan_seg[(j / 4) % 4]});
        end
        bus_write(4'd0, 32'h2);
        next_out();
        check("scan_off", {28'd0, dig_sel}, 32'd0);

        // blank and DP masks
        bus_write(4'd0, 32'h3);
        bus_write(4'd1, 32'h2);
        bus_write(4'd3, 32'h1);
        next_out();
        check("blank_byte1", {24'd0, seg_static[15:8]}, 32'hFF);
        check("dp_byte0", {24'd0, seg_static[7:0]}, 32'h40);

        // blink
        bus_write(4'd1, 32'h0);
        bus_write(4'd2, 32'h4);
        bus_write(4'd0, 32'h7);
        for (int j = 0; j < 32; j++) begin
            next_out();
            check("blink_byte2", {24'd0, seg_static[23:16]}, ((j / 8) % 2 == 1) ? 32'hFF : 32'h88);
        end

        // bus edges
        bus_write(4'd9, 32'hFFFF_FFFF);
        bus_read(4'd9, 32'd0, "unmapped_read");
        bus_read(4'd0, 32'd7, "unmapped_no_effect");
        bus_write(4'd4, 32'hFFFF_FFFF);
        bus_read(4'd4, 32'h7F, "digit_width");
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 4'd4;
        writedata  = 32'h11;
        @(negedge clk);
        bus_idle();
        bus_read(4'd4, 32'h7F, "cs_low_ignored");

        // async reset mid-scan (index 2, blink phase 1)
        bus_write(4'd0, 32'h0);
        bus_write(4'd0, 32'h7);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_dig_sel", {28'd0, dig_sel}, 32'h4);
        check("pre_rst_byte2", {24'd0, seg_static[23:16]}, 32'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_seg_static", seg_static, 32'hFFFF_FFFF);
        check("mid_rst_seg_mux", {25'd0, seg_mux}, 32'h7F);
        check("mid_rst_dp_mux", {31'd0, dp_mux}, 32'd1);
        check("mid_rst_dig_sel", {28'd0, dig_sel}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(4'd0, 32'd0, "post_rst_ctrl");
        bus_write(4'd0, 32'h1);
        for (int j = 0; j < 8; j++) begin
            next_out();
            check("restart_dig_sel", {28'd0, dig_sel}, 32'(1 << (j / 4)));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
